// File: rtl/reset_release_sequencer.sv
// rtl/reset_release_sequencer.sv - staged release of active-low resets with REQ/ACK soft-reset handshake
module reset_release_sequencer #(
    parameter int NUM_OUT  = 2,
    parameter int RSTDELAY = 2,
    parameter int STAGGER  = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               REQ,
    output logic               BUSY,
    output logic               ACK,
    output logic [NUM_OUT-1:0] OUT_RST_N
);

    localparam int MAX_D = (RSTDELAY > STAGGER) ? RSTDELAY : STAGGER;
    localparam int CNT_W = $clog2(MAX_D + 1);
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RSTDELAY - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_OUT - 1);

    generate
        if (NUM_OUT < 1 || RSTDELAY < 1 || STAGGER < 1) begin : g_bad_params
            $error("reset_release_sequencer: NUM_OUT, RSTDELAY and STAGGER must all be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Every output is computed one cycle ahead so the pins come straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;
        ack_d   = 1'b0;
        case (state_q)
            HOLD: begin
                out_d = '0;
                if (cnt_q == HOLD_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == STAGGER_LAST) begin
                    out_d[idx_q] = 1'b1;
                    cnt_d        = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ack_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                out_d = '1;
                if (REQ) begin
                    state_d = HOLD;
                    out_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = HOLD;
                out_d   = '0;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d != RUN);
    end

    assign OUT_RST_N = out_q;
    assign ACK       = ack_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb/tb_reset_release_sequencer.sv - bench for reset_release_sequencer with an edge-count model
module tb_reset_release_sequencer;

    logic       CLK = 1'b0;
    logic       a_rst, a_req, b_rst, b_req;
    logic       a_busy, a_ack, b_busy, b_ack;
    logic [1:0] a_out;
    logic [3:0] b_out;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    reset_release_sequencer #(.NUM_OUT(2), .RSTDELAY(2), .STAGGER(1)) dut_a (
        .CLK(CLK), .RST(a_rst), .REQ(a_req),
        .BUSY(a_busy), .ACK(a_ack), .OUT_RST_N(a_out)
    );

    reset_release_sequencer #(.NUM_OUT(4), .RSTDELAY(3), .STAGGER(2)) dut_b (
        .CLK(CLK), .RST(b_rst), .REQ(b_req),
        .BUSY(b_busy), .ACK(b_ack), .OUT_RST_N(b_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: count edges since the sequence started; bit k is released once that
    // count reaches RSTDELAY+(k+1)*STAGGER, and the run completes at NUM_OUT*STAGGER past the hold.
    int   m_since [2];
    bit   m_run   [2];
    bit   m_ack   [2];
    bit   m_valid [2] = '{0, 0};

    function automatic int p_num(input int i);  return (i == 0) ? 2 : 4; endfunction
    function automatic int p_dly(input int i);  return (i == 0) ? 2 : 3; endfunction
    function automatic int p_stg(input int i);  return (i == 0) ? 1 : 2; endfunction

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            logic r, q;
            int   done_at;
            r       = (i == 0) ? a_rst : b_rst;
            q       = (i == 0) ? a_req : b_req;
            done_at = p_dly(i) + p_num(i) * p_stg(i);
            m_ack[i] = 1'b0;
            if (r) begin
                m_since[i] = 0;
                m_run[i]   = 1'b0;
                m_valid[i] = 1'b1;
            end else if (m_run[i] && q) begin
                m_since[i] = 0;
                m_run[i]   = 1'b0;
            end else if (!m_run[i]) begin
                m_since[i]++;
                if (m_since[i] == done_at) begin
                    m_run[i] = 1'b1;
                    m_ack[i] = 1'b1;
                end
            end
        end
    end

    function automatic logic [3:0] m_out(input int i);
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < p_num(i); k++)
            v[k] = m_run[i] || (m_since[i] >= p_dly(i) + (k + 1) * p_stg(i));
        return v;
    endfunction

    always @(negedge CLK) begin
        if (m_valid[0]) begin
            chk("a_out",  {30'd0, a_out}, {28'd0, m_out(0)});
            chk("a_ack",  {31'd0, a_ack}, {31'd0, m_ack[0]});
            chk("a_busy", {31'd0, a_busy}, {31'd0, !m_run[0]});
        end
        if (m_valid[1]) begin
            chk("b_out",  {28'd0, b_out}, {28'd0, m_out(1)});
            chk("b_ack",  {31'd0, b_ack}, {31'd0, m_ack[1]});
            chk("b_busy", {31'd0, b_busy}, {31'd0, !m_run[1]});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hand-computed defaults timeline for instance A, edges e1..e5 after the sequence start.
    task automatic check_a_seq(input int req_from, input int req_to);
        logic [1:0] exp_out [1:5];
        exp_out = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b11};
        for (int e = 1; e <= 5; e++) begin
            a_req = (e >= req_from && e <= req_to);
            tick();
            chk($sformatf("seq_a_out_e%0d", e), {30'd0, a_out}, {30'd0, exp_out[e]});
            chk($sformatf("seq_a_ack_e%0d", e), {31'd0, a_ack}, {31'd0, (e == 4)});
            chk($sformatf("seq_a_busy_e%0d", e), {31'd0, a_busy}, {31'd0, (e < 4)});
        end
        a_req = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_b [1:12];
        exp_b = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001,
                  4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
        a_rst = 1'b1; a_req = 1'b0;
        b_rst = 1'b1; b_req = 1'b0;
        repeat (3) tick();
        chk("rst_a_out",  {30'd0, a_out}, 32'd0);
        chk("rst_a_busy", {31'd0, a_busy}, 32'd1);
        chk("rst_a_ack",  {31'd0, a_ack}, 32'd0);
        chk("rst_b_out",  {28'd0, b_out}, 32'd0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Tests 1 and 2 run side by side on the two instances.
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e <= 5) begin
                chk($sformatf("t1_a_out_e%0d", e), {30'd0, a_out},
                    (e <= 2) ? 32'd0 : (e == 3) ? 32'd1 : 32'd3);
                chk($sformatf("t1_a_ack_e%0d", e), {31'd0, a_ack}, {31'd0, (e == 4)});
                chk($sformatf("t1_a_busy_e%0d", e), {31'd0, a_busy}, {31'd0, (e < 4)});
            end
            chk($sformatf("t2_b_out_e%0d", e), {28'd0, b_out}, {28'd0, exp_b[e]});
            chk($sformatf("t2_b_ack_e%0d", e), {31'd0, b_ack}, {31'd0, (e == 11)});
        end

        // Test 3: one-cycle REQ in RUN
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        chk("t3_req_out",  {30'd0, a_out}, 32'd0);
        chk("t3_req_busy", {31'd0, a_busy}, 32'd1);
        check_a_seq(0, -1);

        // Test 4: REQ held through HOLD and RELEASE is ignored
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        check_a_seq(1, 4);
        tick();
        chk("t4_no_restart", {30'd0, a_out}, 32'd3);

        // Test 5: RST right after bit 0 is released aborts without ACK
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        repeat (3) tick();
        chk("t5_bit0", {30'd0, a_out}, 32'd1);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        chk("t5_abort_out", {30'd0, a_out}, 32'd0);
        chk("t5_abort_ack", {31'd0, a_ack}, 32'd0);
        check_a_seq(0, -1);

        // Test 6: RST together with REQ in RUN
        a_rst = 1'b1;
        a_req = 1'b1;
        tick();
        a_rst = 1'b0;
        a_req = 1'b0;
        chk("t6_out",  {30'd0, a_out}, 32'd0);
        chk("t6_busy", {31'd0, a_busy}, 32'd1);
        check_a_seq(0, -1);

        // Soft request on instance B to exercise the wider configuration
        b_req = 1'b1;
        tick();
        b_req = 1'b0;
        chk("b_req_out", {28'd0, b_out}, 32'd0);
        repeat (12) tick();
        chk("b_req_done", {28'd0, b_out}, 32'hf);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
